// File: rtl/dtack_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dtack_generator_pkg
// Description : Shared types and default constants for the 68000 DTACK/BERR
//               generator: bus-cycle state encoding, selected-device
//               encoding, default wait-state and bus-error timeout values.
// Revision    : 1.0 - initial release
// ============================================================================
package dtack_generator_pkg;

    // Bus-cycle tracking states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_BERR = 2'd3
    } state_e;

    // Device latched at the start of a bus cycle
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ROM  = 2'd1,
        SEL_RAM  = 2'd2,
        SEL_IO   = 2'd3
    } sel_e;

    localparam int DEF_WAIT_ROM     = 2;
    localparam int DEF_WAIT_RAM     = 0;
    localparam int DEF_BERR_TIMEOUT = 64;
    localparam int WAIT_CNT_W       = 4;

endpackage : dtack_generator_pkg
`default_nettype wire

// File: rtl/cpuclk_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : cpuclk_edge_detect
// Description : Registers the divided CPU clock on the master clock and
//               flags its rising edge for one master-clock period.
// Ports       : MCLK_IN    - master clock
//               RESET_N_IN - asynchronous active-low reset
//               CPUCLK_IN  - CPU clock, synchronous to MCLK_IN
//               TICK_OUT   - high for one MCLK when CPUCLK_IN rises
// Revision    : 1.0 - initial release
// ============================================================================
module cpuclk_edge_detect (
    input  logic MCLK_IN,
    input  logic RESET_N_IN,
    input  logic CPUCLK_IN,
    output logic TICK_OUT
);

    logic cpuclk_q;

    // Cleared by reset so the first tick afterwards is judged against 0
    always_ff @(posedge MCLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            cpuclk_q <= 1'b0;
        end else begin
            cpuclk_q <= CPUCLK_IN;
        end
    end

    assign TICK_OUT = CPUCLK_IN & ~cpuclk_q;

endmodule : cpuclk_edge_detect
`default_nettype wire

// File: rtl/dtack_generator.sv
`default_nettype none
// ============================================================================
// Module      : dtack_generator
// Description : Tracks 68000 bus cycles and generates DTACK after a per-device
//               number of wait states (ROM/RAM) or on device ready (I/O).
//               Unacknowledged cycles end in a bus error after BERR_TIMEOUT
//               CPU clocks. All outputs are registered.
// Ports       : MCLK_IN     - master clock (only clock)
//               RESET_N_IN  - asynchronous active-low reset
//               CPUCLK_IN   - CPU clock, synchronous to MCLK_IN
//               AS_N_IN     - address strobe, active-low
//               ROM_SEL_IN  - ROM decode select
//               RAM_SEL_IN  - RAM decode select
//               IO_SEL_IN   - I/O decode select
//               IO_ACK_IN   - I/O device ready
//               DTACK_N_OUT - data acknowledge, active-low
//               BERR_N_OUT  - bus error, active-low
//               BUSY_OUT    - high while a bus cycle is tracked
// Revision    : 1.0 - initial release
// ============================================================================
module dtack_generator
    import dtack_generator_pkg::*;
#(
    parameter int WAIT_ROM     = DEF_WAIT_ROM,
    parameter int WAIT_RAM     = DEF_WAIT_RAM,
    parameter int BERR_TIMEOUT = DEF_BERR_TIMEOUT
) (
    input  logic MCLK_IN,
    input  logic RESET_N_IN,
    input  logic CPUCLK_IN,
    input  logic AS_N_IN,
    input  logic ROM_SEL_IN,
    input  logic RAM_SEL_IN,
    input  logic IO_SEL_IN,
    input  logic IO_ACK_IN,
    output logic DTACK_N_OUT,
    output logic BERR_N_OUT,
    output logic BUSY_OUT
);

    localparam int                    TO_W     = $clog2(BERR_TIMEOUT);
    localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(BERR_TIMEOUT - 1);
    localparam logic [WAIT_CNT_W-1:0] C_WROM   = WAIT_CNT_W'(WAIT_ROM);
    localparam logic [WAIT_CNT_W-1:0] C_WRAM   = WAIT_CNT_W'(WAIT_RAM);

    logic                  tick;
    state_e                state_q, state_d;
    sel_e                  sel_q, sel_d;
    logic [WAIT_CNT_W-1:0] wait_q, wait_d;
    logic [TO_W-1:0]       to_q, to_d;
    logic [TO_W-1:0]       to_inc;
    logic                  ack;
    logic                  dtack_n_q, dtack_n_d;
    logic                  berr_n_q, berr_n_d;
    logic                  busy_q, busy_d;

    cpuclk_edge_detect u_edge (
        .MCLK_IN    (MCLK_IN),
        .RESET_N_IN (RESET_N_IN),
        .CPUCLK_IN  (CPUCLK_IN),
        .TICK_OUT   (tick)
    );

    always_ff @(posedge MCLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state_q   <= ST_IDLE;
            sel_q     <= SEL_NONE;
            wait_q    <= '0;
            to_q      <= '0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            wait_q    <= wait_d;
            to_q      <= to_d;
            dtack_n_q <= dtack_n_d;
            berr_n_q  <= berr_n_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wait_d  = wait_q;
        to_d    = to_q;
        // Saturating increment of the timeout counter
        to_inc  = (to_q == '1) ? to_q : to_q + TO_W'(1);
        // Memory acknowledges on the tick that consumes its last wait state
        ack     = (((sel_q == SEL_ROM) || (sel_q == SEL_RAM)) && (wait_q <= WAIT_CNT_W'(1)))
                || ((sel_q == SEL_IO) && IO_ACK_IN);

        case (state_q)
            ST_IDLE: begin
                if (tick && !AS_N_IN) begin
                    to_d = '0;
                    if (ROM_SEL_IN) begin
                        sel_d   = SEL_ROM;
                        wait_d  = C_WROM;
                        state_d = (C_WROM == '0) ? ST_ACK : ST_WAIT;
                    end else if (RAM_SEL_IN) begin
                        sel_d   = SEL_RAM;
                        wait_d  = C_WRAM;
                        state_d = (C_WRAM == '0) ? ST_ACK : ST_WAIT;
                    end else if (IO_SEL_IN) begin
                        sel_d   = SEL_IO;
                        wait_d  = '0;
                        state_d = ST_WAIT;
                    end else begin
                        sel_d   = SEL_NONE;
                        wait_d  = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (AS_N_IN) begin
                    // CPU abandoned the cycle: no acknowledge, no bus error
                    state_d = ST_IDLE;
                end else if (tick) begin
                    to_d   = to_inc;
                    wait_d = (wait_q != '0) ? wait_q - WAIT_CNT_W'(1) : wait_q;
                    // Acknowledge wins over a timeout landing on the same tick
                    if (ack) begin
                        state_d = ST_ACK;
                    end else if (to_inc >= TO_LAST) begin
                        state_d = ST_BERR;
                    end
                end
            end
            ST_ACK, ST_BERR: begin
                if (AS_N_IN) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered images of the next state, so DTACK and BERR
        // are mutually exclusive by construction
        dtack_n_d = (state_d != ST_ACK);
        berr_n_d  = (state_d != ST_BERR);
        busy_d    = (state_d != ST_IDLE);
    end

    assign DTACK_N_OUT = dtack_n_q;
    assign BERR_N_OUT  = berr_n_q;
    assign BUSY_OUT    = busy_q;

endmodule : dtack_generator
`default_nettype wire

// File: tb/tb_dtack_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_dtack_generator
// Description : Directed self-checking bench for dtack_generator. A default
//               instance (ROM 2, RAM 0, timeout 64) and a WAIT_ROM=3 instance
//               share the same stimulus. CPUCLK runs at MCLK/2, so a tick
//               falls on every second MCLK rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dtack_generator;

    logic mclk    = 1'b0;
    logic rst_n   = 1'b0;
    logic cpuclk  = 1'b0;
    logic as_n    = 1'b1;
    logic rom_sel = 1'b0;
    logic ram_sel = 1'b0;
    logic io_sel  = 1'b0;
    logic io_ack  = 1'b0;
    logic dtack_n, berr_n, busy;
    logic dtack3_n, berr3_n, busy3;

    int checks = 0;
    int errors = 0;

    always #5 mclk = ~mclk;
    always @(negedge mclk) cpuclk <= ~cpuclk;

    dtack_generator dut (
        .MCLK_IN(mclk), .RESET_N_IN(rst_n), .CPUCLK_IN(cpuclk), .AS_N_IN(as_n),
        .ROM_SEL_IN(rom_sel), .RAM_SEL_IN(ram_sel), .IO_SEL_IN(io_sel),
        .IO_ACK_IN(io_ack), .DTACK_N_OUT(dtack_n), .BERR_N_OUT(berr_n),
        .BUSY_OUT(busy)
    );

    dtack_generator #(.WAIT_ROM(3)) dut3 (
        .MCLK_IN(mclk), .RESET_N_IN(rst_n), .CPUCLK_IN(cpuclk), .AS_N_IN(as_n),
        .ROM_SEL_IN(rom_sel), .RAM_SEL_IN(ram_sel), .IO_SEL_IN(io_sel),
        .IO_ACK_IN(io_ack), .DTACK_N_OUT(dtack3_n), .BERR_N_OUT(berr3_n),
        .BUSY_OUT(busy3)
    );

    // Position just before an MCLK rising edge that is a tick
    task automatic to_tick_setup();
        for (int i = 0; i < 4; i++) begin
            @(negedge mclk);
            #1;
            if (cpuclk) break;
        end
    endtask

    // Advance one MCLK rising edge and settle
    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL reset_dtack: got %b want 1", dtack_n); end
        checks++; if (berr_n !== 1'b1)  begin errors++; $display("FAIL reset_berr: got %b want 1", berr_n); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (busy3 !== 1'b0 || dtack3_n !== 1'b1 || berr3_n !== 1'b1) begin
            errors++; $display("FAIL reset_dut3: got busy=%b dtack=%b berr=%b want 0 1 1", busy3, dtack3_n, berr3_n);
        end
        @(negedge mclk); #1;
        rst_n = 1'b1;
        step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy got %b want 0", busy); end
    endtask

    task automatic test_ram_zero_wait();
        to_tick_setup();
        as_n = 1'b0; ram_sel = 1'b1;
        step();
        checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL ram_dtack_on_tick: got %b want 0", dtack_n); end
        checks++; if (busy !== 1'b1 || berr_n !== 1'b1) begin
            errors++; $display("FAIL ram_busy_berr: got busy=%b berr=%b want 1 1", busy, berr_n);
        end
        // Next edge is not a tick: release must still happen on it
        as_n = 1'b1; ram_sel = 1'b0;
        step();
        checks++; if (dtack_n !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL ram_release: got dtack=%b busy=%b want 1 0", dtack_n, busy);
        end
    endtask

    task automatic test_rom_wait();
        to_tick_setup();
        as_n = 1'b0; rom_sel = 1'b1;
        step();
        checks++; if (dtack_n !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rom_start: got dtack=%b busy=%b want 1 1", dtack_n, busy);
        end
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++; if (dtack_n !== ((i >= 4) ? 1'b0 : 1'b1) || busy !== 1'b1) begin
                errors++; $display("FAIL rom2_mclk%0d: got dtack=%b busy=%b want %b 1", i, dtack_n, busy, (i >= 4) ? 1'b0 : 1'b1);
            end
            if (i == 4 || i == 6) begin
                checks++; if (dtack3_n !== ((i >= 6) ? 1'b0 : 1'b1)) begin
                    errors++; $display("FAIL rom3_mclk%0d: got dtack=%b want %b", i, dtack3_n, (i >= 6) ? 1'b0 : 1'b1);
                end
            end
        end
        as_n = 1'b1; rom_sel = 1'b0;
        step();
        checks++; if (dtack_n !== 1'b1 || dtack3_n !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rom_release: got dtack=%b dtack3=%b busy=%b want 1 1 0", dtack_n, dtack3_n, busy);
        end
    endtask

    task automatic test_io();
        to_tick_setup();
        as_n = 1'b0; io_sel = 1'b1; io_ack = 1'b0;
        step();
        for (int k = 1; k <= 10; k++) begin
            step(); step();
            checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL io_wait_tick%0d: got dtack=%b want 1", k, dtack_n); end
        end
        io_ack = 1'b1;
        step();
        checks++; if (dtack_n !== 1'b1) begin errors++; $display("FAIL io_ack_off_tick: got dtack=%b want 1", dtack_n); end
        step();
        checks++; if (dtack_n !== 1'b0 || berr_n !== 1'b1) begin
            errors++; $display("FAIL io_ack_tick: got dtack=%b berr=%b want 0 1", dtack_n, berr_n);
        end
        as_n = 1'b1; io_sel = 1'b0; io_ack = 1'b0;
        step();
        checks++; if (dtack_n !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL io_release: got dtack=%b busy=%b want 1 0", dtack_n, busy);
        end
    endtask

    task automatic test_berr_timeout();
        to_tick_setup();
        as_n = 1'b0;
        step();
        for (int k = 1; k <= 63; k++) begin
            step(); step();
            if (k < 63) begin
                checks++; if (berr_n !== 1'b1 || dtack_n !== 1'b1) begin
                    errors++; $display("FAIL berr_early_tick%0d: got berr=%b dtack=%b want 1 1", k, berr_n, dtack_n);
                end
            end else begin
                checks++; if (berr_n !== 1'b0 || dtack_n !== 1'b1 || busy !== 1'b1) begin
                    errors++; $display("FAIL berr_tick63: got berr=%b dtack=%b busy=%b want 0 1 1", berr_n, dtack_n, busy);
                end
            end
        end
        as_n = 1'b1;
        step();
        checks++; if (berr_n !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL berr_release: got berr=%b busy=%b want 1 0", berr_n, busy);
        end
    endtask

    task automatic test_ack_vs_timeout();
        to_tick_setup();
        as_n = 1'b0; io_sel = 1'b1; io_ack = 1'b0;
        step();
        for (int k = 1; k <= 62; k++) begin
            step(); step();
        end
        io_ack = 1'b1;
        step(); step();
        checks++; if (dtack_n !== 1'b0 || berr_n !== 1'b1) begin
            errors++; $display("FAIL ack_beats_timeout: got dtack=%b berr=%b want 0 1", dtack_n, berr_n);
        end
        as_n = 1'b1; io_sel = 1'b0; io_ack = 1'b0;
        step();
    endtask

    task automatic test_abort();
        to_tick_setup();
        as_n = 1'b0; rom_sel = 1'b1;
        step(); step(); step();
        as_n = 1'b1; rom_sel = 1'b0;
        step();
        checks++; if (busy3 !== 1'b0 || dtack3_n !== 1'b1) begin
            errors++; $display("FAIL abort_idle: got busy3=%b dtack3=%b want 0 1", busy3, dtack3_n);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (dtack3_n !== 1'b1 || berr3_n !== 1'b1 || dtack_n !== 1'b1) begin
                errors++; $display("FAIL abort_quiet%0d: got dtack3=%b berr3=%b dtack=%b want 1 1 1", i, dtack3_n, berr3_n, dtack_n);
            end
        end
    endtask

    task automatic test_reset_mid_ack();
        to_tick_setup();
        as_n = 1'b0; ram_sel = 1'b1;
        step();
        checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL rst_pre_ack: got dtack=%b want 0", dtack_n); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (dtack_n !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_async_release: got dtack=%b busy=%b want 1 0", dtack_n, busy);
        end
        @(negedge mclk); #1;
        as_n = 1'b1; ram_sel = 1'b0; rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 2; n++) begin
            to_tick_setup();
            as_n = 1'b0; ram_sel = 1'b1;
            step();
            checks++; if (dtack_n !== 1'b0) begin errors++; $display("FAIL b2b_ack%0d: got dtack=%b want 0", n, dtack_n); end
            as_n = 1'b1; ram_sel = 1'b0;
            step();
            checks++; if (dtack_n !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL b2b_release%0d: got dtack=%b busy=%b want 1 0", n, dtack_n, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ram_zero_wait();
        test_rom_wait();
        test_io();
        test_berr_timeout();
        test_ack_vs_timeout();
        test_abort();
        test_reset_mid_ack();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule : tb_dtack_generator
`default_nettype wire
